// File: rtl/ps_step_responder_if.sv
// Calibration step-request / MMCM DPS bundle for ps_step_responder.
// PS_STEP_STATS_EN adds the step/timeout statistics counters to the bundle.
interface ps_step_responder_if #(
    parameter int POS_W = 16
);
    logic                    req_psen;
    logic                    req_dincr;
    logic                    clr_pos;
    logic                    mmcm_psdone;
    logic                    mmcm_psen;
    logic                    mmcm_psincdec;
    logic                    busy;
    logic                    step_ack;
    logic signed [POS_W-1:0] phase_pos;
    logic                    limit_hit;
    logic                    timeout_err;
`ifdef PS_STEP_STATS_EN
    logic [31:0]             inc_count;
    logic [31:0]             dec_count;
    logic [7:0]              timeout_count;

    modport slave (
        input  req_psen, req_dincr, clr_pos, mmcm_psdone,
        output mmcm_psen, mmcm_psincdec, busy, step_ack, phase_pos, limit_hit, timeout_err,
        output inc_count, dec_count, timeout_count
    );
    modport master (
        output req_psen, req_dincr, clr_pos, mmcm_psdone,
        input  mmcm_psen, mmcm_psincdec, busy, step_ack, phase_pos, limit_hit, timeout_err,
        input  inc_count, dec_count, timeout_count
    );
`else
    modport slave (
        input  req_psen, req_dincr, clr_pos, mmcm_psdone,
        output mmcm_psen, mmcm_psincdec, busy, step_ack, phase_pos, limit_hit, timeout_err
    );
    modport master (
        output req_psen, req_dincr, clr_pos, mmcm_psdone,
        input  mmcm_psen, mmcm_psincdec, busy, step_ack, phase_pos, limit_hit, timeout_err
    );
`endif
endinterface

// File: rtl/ps_step_responder.sv
// Turns level step requests into MMCM DPS psen/psdone transactions and tracks phase position.
// Optional PS_STEP_STATS_EN adds saturating inc/dec/timeout counters.
module ps_step_responder #(
    parameter int POS_W      = 16,
    parameter int POS_MAX    = 1120,
    parameter int TIMEOUT    = 64,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rstn,
    ps_step_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic signed [POS_W-1:0] PMAX = POS_W'(POS_MAX);
    localparam logic signed [POS_W-1:0] PMIN = -PMAX;
    localparam logic signed [POS_W-1:0] ONE  = POS_W'(1);

    state_t                  state_q, state_d;
    logic                    dir_q, dir_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic                    ack_q, ack_d;
    logic                    lim_q, lim_d;
    logic                    err_q, err_d;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        tmo_d   = tmo_q;
        gap_d   = gap_q;
        pos_d   = pos_q;
        ack_d   = 1'b0;
        lim_d   = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_psen) begin
                    dir_d = bus.req_dincr;
                    if (bus.req_dincr ? (pos_q == PMAX) : (pos_q == PMIN)) lim_d = 1'b1;
                    else                                                     state_d = ISSUE;
                end
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                tmo_d = tmo_q + TW'(1);
                // psdone on the terminal count still completes the step
                if (bus.mmcm_psdone) begin
                    pos_d   = dir_q ? pos_q + ONE : pos_q - ONE;
                    ack_d   = 1'b1;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // clear overrides a coincident position update or timeout
        if (bus.clr_pos) begin
            pos_d = '0;
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            tmo_q   <= '0;
            gap_q   <= '0;
            pos_q   <= '0;
            ack_q   <= 1'b0;
            lim_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            pos_q   <= pos_d;
            ack_q   <= ack_d;
            lim_q   <= lim_d;
            err_q   <= err_d;
        end
    end

    assign bus.mmcm_psen     = (state_q == ISSUE);
    assign bus.mmcm_psincdec = (state_q == ISSUE) & dir_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.step_ack      = ack_q;
    assign bus.phase_pos     = pos_q;
    assign bus.limit_hit     = lim_q;
    assign bus.timeout_err   = err_q;

`ifdef PS_STEP_STATS_EN
    logic [31:0] inc_q, dec_q;
    logic [7:0]  tcnt_q;
    logic        tmo_evt;

    assign tmo_evt = (state_q == WAIT_DONE) && !bus.mmcm_psdone && (tmo_q == TW'(TIMEOUT - 1));

    // dir_q is still the completed step's direction while step_ack is high
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inc_q  <= '0;
            dec_q  <= '0;
            tcnt_q <= '0;
        end else begin
            if (ack_q && dir_q && (inc_q != '1))   inc_q  <= inc_q + 32'd1;
            if (ack_q && !dir_q && (dec_q != '1))  dec_q  <= dec_q + 32'd1;
            if (tmo_evt && (tcnt_q != '1))         tcnt_q <= tcnt_q + 8'd1;
        end
    end

    assign bus.inc_count     = inc_q;
    assign bus.dec_count     = dec_q;
    assign bus.timeout_count = tcnt_q;
`endif
endmodule

// File: tb/tb_ps_step_responder.sv
// Randomized transaction-level check of ps_step_responder against a position/error model.
module tb_ps_step_responder;
    localparam int POS_W   = 16;
    localparam int POS_MAX = 12;
    localparam int TMO     = 16;
    localparam int GAPC    = 2;

    logic clk;
    logic rstn;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   m_pos = 0;
    int   m_err = 0;

    ps_step_responder_if #(.POS_W(POS_W)) bus ();

    ps_step_responder #(
        .POS_W(POS_W), .POS_MAX(POS_MAX), .TIMEOUT(TMO), .GAP_CYCLES(GAPC)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // all sampling and driving happens on the falling edge
    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin tick(); n++; end
        if (n >= 100) chk("idle_timeout", 1, 0);
    endtask

    task automatic do_clr();
        bus.clr_pos = 1'b1;
        tick();
        bus.clr_pos = 1'b0;
        m_pos = 0;
        m_err = 0;
        chk("clr_pos", bus.phase_pos, 0);
        chk("clr_err", bus.timeout_err, 0);
    endtask

    // lat = cycle after psen in which psdone is returned (0: never)
    task automatic do_step(input bit dir, input int lat, input bit clr_with);
        bit at_lim;
        bit done;
        wait_idle();
        at_lim = dir ? (m_pos == POS_MAX) : (m_pos == -POS_MAX);
        bus.req_psen  = 1'b1;
        bus.req_dincr = dir;
        tick();
        bus.req_psen  = 1'b0;
        bus.req_dincr = 1'($urandom);
        if (at_lim) begin
            chk("lim_hit", bus.limit_hit, 1);
            chk("lim_psen", bus.mmcm_psen, 0);
            chk("lim_busy", bus.busy, 0);
            tick();
            chk("lim_pulse", bus.limit_hit, 0);
            chk("lim_pos", bus.phase_pos, m_pos);
            return;
        end
        chk("psen", bus.mmcm_psen, 1);
        chk("incdec", bus.mmcm_psincdec, int'(dir));
        chk("no_lim", bus.limit_hit, 0);
        done = 1'b0;
        for (int n = 1; n <= TMO; n++) begin
            tick();
            chk("w_psen", bus.mmcm_psen, 0);
            chk("w_busy", bus.busy, 1);
            chk("w_err", bus.timeout_err, m_err);
            if (n == lat) begin
                bus.mmcm_psdone = 1'b1;
                bus.clr_pos     = clr_with;
                done = 1'b1;
                break;
            end
        end
        tick();
        bus.mmcm_psdone = 1'b0;
        bus.clr_pos     = 1'b0;
        if (done) begin
            m_pos = clr_with ? 0 : m_pos + (dir ? 1 : -1);
            if (clr_with) m_err = 0;
            chk("ack", bus.step_ack, 1);
            chk("pos", bus.phase_pos, m_pos);
            chk("err_keep", bus.timeout_err, m_err);
            chk("gap_busy0", bus.busy, int'(GAPC > 0));
            for (int g = 1; g < GAPC; g++) begin
                tick();
                chk("gap_busy", bus.busy, 1);
                chk("ack_single", bus.step_ack, 0);
            end
            tick();
            chk("back_idle", bus.busy, 0);
            chk("gap_psen", bus.mmcm_psen, 0);
        end else begin
            // WAIT_DONE lasts TMO cycles; the error shows right after the last one
            m_err = 1;
            chk("tmo_err", bus.timeout_err, 1);
            chk("tmo_busy", bus.busy, 0);
            chk("tmo_pos", bus.phase_pos, m_pos);
            chk("tmo_ack", bus.step_ack, 0);
        end
    endtask

    initial begin
        int last, npulse, nack, due, start;
        bit prev_psen;
        rstn = 1'b0;
        bus.req_psen = 1'b0;
        bus.req_dincr = 1'b0;
        bus.clr_pos = 1'b0;
        bus.mmcm_psdone = 1'b0;
        repeat (3) tick();
        chk("rst_psen", bus.mmcm_psen, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_pos", bus.phase_pos, 0);
        chk("rst_ack", bus.step_ack, 0);
        chk("rst_lim", bus.limit_hit, 0);
        chk("rst_err", bus.timeout_err, 0);
        rstn = 1'b1;
        tick();

        // held request: 10 increments, psdone 3 cycles after each psen
        bus.req_psen  = 1'b1;
        bus.req_dincr = 1'b1;
        last = -1; npulse = 0; nack = 0; due = -1; prev_psen = 1'b0;
        start = m_pos;
        for (int c = 0; c < 150; c++) begin
            tick();
            bus.mmcm_psdone = 1'b0;
            if (bus.step_ack) nack++;
            if (bus.mmcm_psen) begin
                chk("held_single", int'(prev_psen), 0);
                chk("held_incdec", bus.mmcm_psincdec, 1);
                if (last >= 0) chk("held_spacing", cyc - last, 2 + 3 + GAPC);
                last = cyc;
                npulse++;
                due = cyc + 3;
                if (npulse == 10) bus.req_psen = 1'b0;
            end
            if (cyc == due) bus.mmcm_psdone = 1'b1;
            prev_psen = bus.mmcm_psen;
            if (nack == 10 && !bus.busy) break;
        end
        m_pos = start + 10;
        chk("held_pulses", npulse, 10);
        chk("held_acks", nack, 10);
        chk("held_pos", bus.phase_pos, m_pos);

        // stray psdone while idle at position 7
        do_clr();
        for (int i = 0; i < 7; i++) do_step(1'b1, 1 + (i % 3), 1'b0);
        bus.mmcm_psdone = 1'b1;
        tick();
        bus.mmcm_psdone = 1'b0;
        tick();
        chk("stray_pos", bus.phase_pos, 7);
        chk("stray_ack", bus.step_ack, 0);
        chk("stray_busy", bus.busy, 0);

        // clear coinciding with psdone of an increment from 5
        do_step(1'b0, 2, 1'b0);
        do_step(1'b0, 1, 1'b0);
        chk("pre_clr_pos", bus.phase_pos, 5);
        do_step(1'b1, 2, 1'b1);

        // decrement to the lower limit, then two refused requests
        for (int i = 0; i < POS_MAX + 2; i++) do_step(1'b0, $urandom_range(1, 4), 1'b0);
        chk("low_limit", bus.phase_pos, -POS_MAX);

        // timeout, then psdone exactly on the terminal count
        do_step(1'b1, 0, 1'b0);
        do_step(1'b1, TMO, 1'b0);
        chk("sticky_err", bus.timeout_err, 1);
        do_clr();

        // reset in the middle of WAIT_DONE
        do_step(1'b1, 1, 1'b0);
        bus.req_psen  = 1'b1;
        bus.req_dincr = 1'b1;
        tick();
        bus.req_psen  = 1'b0;
        tick();
        #2 rstn = 1'b0;
        #1;
        m_pos = 0; m_err = 0;
        chk("mid_rst_pos", bus.phase_pos, 0);
        chk("mid_rst_psen", bus.mmcm_psen, 0);
        chk("mid_rst_busy", bus.busy, 0);
        tick();
        rstn = 1'b1;
        tick();
        bus.mmcm_psdone = 1'b1;
        tick();
        bus.mmcm_psdone = 1'b0;
        chk("post_rst_pos", bus.phase_pos, 0);
        chk("post_rst_ack", bus.step_ack, 0);

        // random mix of steps, timeouts, clears and idle gaps
        for (int i = 0; i < 60; i++) begin
            int lat;
            lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TMO);
            do_step(1'($urandom), lat, ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 9) == 0) do_clr();
            repeat ($urandom_range(0, 2)) tick();
            chk("rnd_pos", bus.phase_pos, m_pos);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end
endmodule
